// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code decoder.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_U     = 8'h3C;

    localparam int unsigned NUM_ACT    = 5;
    localparam int unsigned ACT_LEFT   = 0;
    localparam int unsigned ACT_RIGHT  = 1;
    localparam int unsigned ACT_SELECT = 2;
    localparam int unsigned ACT_DRAW   = 3;
    localparam int unsigned ACT_UNO    = 4;

    // Keyboard housekeeping replies that never form a key code on their own.
    function automatic logic is_ignored(input logic [7:0] b);
        case (b)
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

    function automatic logic [NUM_ACT-1:0] action_onehot(input logic [7:0] code,
                                                         input logic       ext);
        logic [NUM_ACT-1:0] hit;
        hit = '0;
        if (ext && code == SC_LEFT)   hit[ACT_LEFT]   = 1'b1;
        if (ext && code == SC_RIGHT)  hit[ACT_RIGHT]  = 1'b1;
        if (code == SC_ENTER)         hit[ACT_SELECT] = 1'b1;
        if (!ext && code == SC_SPACE) hit[ACT_DRAW]   = 1'b1;
        if (!ext && code == SC_U)     hit[ACT_UNO]    = 1'b1;
        return hit;
    endfunction

endpackage

// File: rtl/ps2_strobe_sync.sv
// Brings the receiver's byte strobe into the clock domain and flags its rising edge.
module ps2_strobe_sync (
    input  logic clock,
    input  logic resetn,
    input  logic strobe_i,
    output logic byte_valid_c_o
);

    // Flops reset high so a strobe already asserted at reset release is not an edge.
    logic [2:0] sync_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], strobe_i};
        end
    end

    assign byte_valid_c_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ps2_key_decoder.sv
// Decodes Set-2 prefix sequences into key events and debounced game-action pulses.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned PAUSE_SKIP     = 7
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_strobe,
    input  logic [7:0] key_byte,
    output logic       key_event,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       act_left,
    output logic       act_right,
    output logic       act_select,
    output logic       act_draw,
    output logic       act_uno,
    output logic       proto_err
);

    localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SKIP_W = $clog2(PAUSE_SKIP + 1);

    logic                byte_valid;
    state_e              state_q, state_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [NUM_ACT-1:0]  held_q, held_d;
    logic [NUM_ACT-1:0]  act_q, act_d;
    logic [7:0]          code_q, code_d;
    logic                ext_q, ext_d;
    logic                rel_q, rel_d;
    logic                event_q, event_d;
    logic                perr_q, perr_d;
    logic                emit, emit_ext, emit_rel;
    logic [NUM_ACT-1:0]  hit;

    ps2_strobe_sync u_sync (
        .clock          (clock),
        .resetn         (resetn),
        .strobe_i       (key_strobe),
        .byte_valid_c_o (byte_valid)
    );

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        skip_d   = skip_q;
        held_d   = held_q;
        code_d   = code_q;
        ext_d    = ext_q;
        rel_d    = rel_q;
        event_d  = 1'b0;
        act_d    = '0;
        perr_d   = 1'b0;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_rel = 1'b0;
        hit      = '0;

        // A byte always wins over a coincident timeout.
        if (byte_valid) begin
            to_cnt_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (key_byte == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (key_byte == SC_BRK) begin
                        state_d = ST_BRK;
                    end else if (key_byte == SC_PAUSE) begin
                        state_d = ST_SKIP;
                        skip_d  = SKIP_W'(PAUSE_SKIP);
                    end else if (!is_ignored(key_byte)) begin
                        emit = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (key_byte == SC_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (key_byte != SC_EXT) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (key_byte == SC_EXT) begin
                        perr_d  = 1'b1;
                        state_d = ST_EXT;
                    end else if (key_byte != SC_BRK) begin
                        emit     = 1'b1;
                        emit_rel = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    if (key_byte == SC_EXT || key_byte == SC_BRK) begin
                        perr_d = 1'b1;
                    end else begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        emit_rel = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - SKIP_W'(1);
                    if (skip_q == SKIP_W'(1)) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d  = ST_IDLE;
                perr_d   = 1'b1;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end

        // Typematic repeats still report the key but re-fire no action until a break.
        if (emit) begin
            event_d = 1'b1;
            code_d  = key_byte;
            ext_d   = emit_ext;
            rel_d   = emit_rel;
            hit     = action_onehot(key_byte, emit_ext);
            if (emit_rel) begin
                held_d = held_q & ~hit;
            end else begin
                act_d  = hit & ~held_q;
                held_d = held_q | hit;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            to_cnt_q <= '0;
            skip_q   <= '0;
            held_q   <= '0;
            act_q    <= '0;
            code_q   <= 8'h00;
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            event_q  <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            skip_q   <= skip_d;
            held_q   <= held_d;
            act_q    <= act_d;
            code_q   <= code_d;
            ext_q    <= ext_d;
            rel_q    <= rel_d;
            event_q  <= event_d;
            perr_q   <= perr_d;
        end
    end

    assign key_event    = event_q;
    assign key_code     = code_q;
    assign key_extended = ext_q;
    assign key_release  = rel_q;
    assign act_left     = act_q[ACT_LEFT];
    assign act_right    = act_q[ACT_RIGHT];
    assign act_select   = act_q[ACT_SELECT];
    assign act_draw     = act_q[ACT_DRAW];
    assign act_uno      = act_q[ACT_UNO];
    assign proto_err    = perr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed self-checking bench for ps2_key_decoder.
module tb_ps2_key_decoder;

    localparam int unsigned TO_CYC = 40;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       key_strobe = 1'b0;
    logic [7:0] key_byte = 8'h00;
    logic       key_event, key_extended, key_release;
    logic [7:0] key_code;
    logic       act_left, act_right, act_select, act_draw, act_uno, proto_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Pulse-high cycle counts, sampled on the falling edge.
    int c_ev = 0, c_left = 0, c_right = 0, c_sel = 0, c_draw = 0, c_uno = 0, c_perr = 0;
    int b_ev, b_left, b_right, b_sel, b_draw, b_uno, b_perr;

    ps2_key_decoder #(.TIMEOUT_CYCLES(TO_CYC), .PAUSE_SKIP(7)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .key_strobe   (key_strobe),
        .key_byte     (key_byte),
        .key_event    (key_event),
        .key_code     (key_code),
        .key_extended (key_extended),
        .key_release  (key_release),
        .act_left     (act_left),
        .act_right    (act_right),
        .act_select   (act_select),
        .act_draw     (act_draw),
        .act_uno      (act_uno),
        .proto_err    (proto_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (key_event)  c_ev    = c_ev + 1;
        if (act_left)   c_left  = c_left + 1;
        if (act_right)  c_right = c_right + 1;
        if (act_select) c_sel   = c_sel + 1;
        if (act_draw)   c_draw  = c_draw + 1;
        if (act_uno)    c_uno   = c_uno + 1;
        if (proto_err)  c_perr  = c_perr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_ev = c_ev; b_left = c_left; b_right = c_right; b_sel = c_sel;
        b_draw = c_draw; b_uno = c_uno; b_perr = c_perr;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock); #1;
        key_byte   = b;
        key_strobe = 1'b1;
        repeat (2) @(posedge clock);
        #1 key_strobe = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic check_fields(input string tag, input logic [7:0] code,
                                input logic ext, input logic rel);
        check({tag, "_code"}, 32'(key_code), 32'(code));
        check({tag, "_ext"},  32'(key_extended), 32'(ext));
        check({tag, "_rel"},  32'(key_release), 32'(rel));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_event", 32'(key_event), 32'd0);
        check_fields("rst", 8'h00, 1'b0, 1'b0);
        check("rst_acts", 32'({act_left, act_right, act_select, act_draw, act_uno, proto_err}), 32'd0);
        resetn = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        // Extended make, repeat, break
        snap();
        send_byte(8'hE0); send_byte(8'h6B);
        check("ext_make_ev", 32'(c_ev - b_ev), 32'd1);
        check_fields("ext_make", 8'h6B, 1'b1, 1'b0);
        check("ext_make_left", 32'(c_left - b_left), 32'd1);
        send_byte(8'hE0); send_byte(8'h6B);
        check("ext_rep_ev", 32'(c_ev - b_ev), 32'd2);
        check("ext_rep_left", 32'(c_left - b_left), 32'd1);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        check("ext_brk_ev", 32'(c_ev - b_ev), 32'd3);
        check_fields("ext_brk", 8'h6B, 1'b1, 1'b1);
        check("ext_brk_left", 32'(c_left - b_left), 32'd1);

        // Plain and keypad codes
        snap();
        send_byte(8'h29);
        check("space_draw", 32'(c_draw - b_draw), 32'd1);
        check_fields("space", 8'h29, 1'b0, 1'b0);
        send_byte(8'hF0); send_byte(8'h29);
        check_fields("space_brk", 8'h29, 1'b0, 1'b1);
        check("space_brk_draw", 32'(c_draw - b_draw), 32'd1);
        send_byte(8'h6B);
        check_fields("kp4", 8'h6B, 1'b0, 1'b0);
        check("kp4_ev", 32'(c_ev - b_ev), 32'd3);
        check("kp4_noact", 32'((c_left - b_left) + (c_right - b_right) + (c_sel - b_sel) + (c_uno - b_uno)), 32'd0);

        // Pause sequence swallowed
        snap();
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        check("pause_noev", 32'(c_ev - b_ev), 32'd0);
        check("pause_noerr", 32'(c_perr - b_perr), 32'd0);
        send_byte(8'h3C);
        check("u_ev", 32'(c_ev - b_ev), 32'd1);
        check_fields("u", 8'h3C, 1'b0, 1'b0);
        check("u_uno", 32'(c_uno - b_uno), 32'd1);

        // Prefix timeout
        snap();
        send_byte(8'hE0);
        repeat (TO_CYC + 5) @(posedge clock);
        #1;
        check("to_perr", 32'(c_perr - b_perr), 32'd1);
        check("to_noev", 32'(c_ev - b_ev), 32'd0);
        send_byte(8'h5A);
        check_fields("to_enter", 8'h5A, 1'b0, 1'b0);
        check("to_sel", 32'(c_sel - b_sel), 32'd1);

        // Illegal prefix order
        snap();
        send_byte(8'hF0); send_byte(8'hE0);
        check("ill_perr", 32'(c_perr - b_perr), 32'd1);
        check("ill_noev", 32'(c_ev - b_ev), 32'd0);
        send_byte(8'h74);
        check_fields("ill_right", 8'h74, 1'b1, 1'b0);
        check("ill_right_act", 32'(c_right - b_right), 32'd1);
        check("ill_perr_once", 32'(c_perr - b_perr), 32'd1);

        // Mid-sequence reset with strobe held high
        @(posedge clock); #1;
        key_byte   = 8'hE0;
        key_strobe = 1'b1;
        repeat (4) @(posedge clock);
        #1 resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1 snap();
        resetn = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("rr_noev", 32'(c_ev - b_ev), 32'd0);
        check_fields("rr", 8'h00, 1'b0, 1'b0);
        key_strobe = 1'b0;
        repeat (2) @(posedge clock);
        send_byte(8'h5A);
        check("rr_ev", 32'(c_ev - b_ev), 32'd1);
        check_fields("rr_enter", 8'h5A, 1'b0, 1'b0);
        check("rr_sel", 32'(c_sel - b_sel), 32'd1);
        check("rr_noerr", 32'(c_perr - b_perr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the PS/2 receiver's per-byte strobe and scan-code byte, decodes Set-2 prefix sequences (E0 extended, F0 break, E1 pause) into clean key events, and emits one-cycle game-action pulses for the UNO controller. Sits directly downstream of the PS/2 byte receiver and upstream of the game FSM. Runs entirely in the system `clock` domain. Contains its own strobe synchronizer because the receiver runs on the PS/2 clock.

## Interface
- `TIMEOUT_CYCLES`, 2_500_000: idle cycles (50 ms at 50 MHz) after which a pending prefix is abandoned.
- `PAUSE_SKIP`, 7: bytes discarded after E1.
- `clock` in 1: system clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `key_strobe` in 1: receiver byte-ready, asynchronous to `clock`. Must be held ≥1 `clock` period.
- `key_byte` in 8: scan-code byte. Must be stable from `key_strobe` rise until 3 `clock` edges later.
- `key_event` out 1: one-cycle pulse, a complete key code was decoded.
- `key_code` out 8: final code byte; valid with `key_event` and held until the next event.
- `key_extended` out 1: code was E0-prefixed; held with `key_code`.
- `key_release` out 1: code was F0-prefixed (break); held with `key_code`.
- `act_left`, `act_right`, `act_select`, `act_draw`, `act_uno` out 1 each: one-cycle action pulses.
- `proto_err` out 1: one-cycle pulse on a prefix timeout or an illegal prefix order.

## Operation
- **Sync:** 3-flop chain s1→s2→s3 on `key_strobe`; `byte_valid = s2 & ~s3`. All three flops reset to 1, so a strobe that is already high at reset release is not a new byte.
- **States:** IDLE, EXT, BRK, EXT_BRK, SKIP. Decoding happens only on `byte_valid`.
- **IDLE:**
  - E0 → EXT.
  - F0 → BRK.
  - E1 → SKIP, with skip counter = `PAUSE_SKIP`.
  - AA/FA/FE/EE/00/FF → ignored, stay IDLE.
  - Any other byte → event (ext=0, rel=0).
- **EXT:**
  - E0 → stay EXT.
  - F0 → EXT_BRK.
  - Other byte → event (ext=1, rel=0), go to IDLE.
- **BRK:**
  - F0 → stay BRK.
  - E0 → `proto_err` pulse, go to EXT.
  - Other byte → event (ext=0, rel=1), go to IDLE.
- **EXT_BRK:**
  - E0/F0 → `proto_err` pulse, go to IDLE.
  - Other byte → event (ext=1, rel=1), go to IDLE.
- **SKIP:** decrement the counter on each byte; go to IDLE when the counter reaches 0 after the decrement. No events.
- **Action map** (events only):
  - ext=1 6B → left.
  - ext=1 74 → right.
  - 5A (either ext value) → select.
  - ext=0 29 (space) → draw.
  - ext=0 3C (U) → uno.
  - ext=0 6B (keypad 4) maps to no action.
- **Typematic suppression:** `held[4:0]` per action.
  - Make with held=0 → pulse and set held.
  - Make with held=1 → no pulse.
  - Break → clear held, no pulse.
  - `key_event` still fires for repeats.
- **Timeout:** counter runs while in EXT/BRK/EXT_BRK/SKIP and clears on every `byte_valid`. Reaching `TIMEOUT_CYCLES-1` → IDLE and a `proto_err` pulse.
  - Timeout and `byte_valid` in the same cycle: the byte is processed in the current state; no timeout.
- **Reset values:** all pulses 0, `key_code` 00, `key_extended`/`key_release` 0, `held` 0, state IDLE. A mid-sequence reset discards any partial prefix.

## Timing
- `key_strobe` first sampled high at edge N → `byte_valid` high between N+1 and N+2 → `key_event`, action pulses and registered fields update at edge N+2. Latency is 3 edges, counting N.
- Every pulse output is exactly 1 cycle wide and registered.
- Minimum byte spacing: 4 `clock` cycles (strobe low ≥1 cycle between bytes). PS/2 rates satisfy this by a wide margin.
- `key_code`, `key_extended` and `key_release` change only on the `key_event` cycle.

## Structure
- **`ps2_pkg`:**
  - state enum.
  - scan-code constants: `SC_EXT`=E0, `SC_BRK`=F0, `SC_PAUSE`=E1, `SC_LEFT`=6B, `SC_RIGHT`=74, `SC_ENTER`=5A, `SC_SPACE`=29, `SC_U`=3C, and the ignored-code list.
  - action index constants 0–4.
- **Sub-module `ps2_strobe_sync`:** the 3-flop synchronizer plus edge detect, with reset-to-1 flops.
- Decoder FSM, timeout counter, skip counter and held register live in `ps2_key_decoder`.

## Test plan
- **Extended make/break with repeat:** send E0 6B, E0 6B, E0 F0 6B.
  - Three `key_event` pulses: (6B, ext=1, rel=0) twice, then (6B, ext=1, rel=1).
  - `act_left` pulses exactly once, on the first event.
- **Plain and keypad codes:** send 29, then F0 29, then 6B.
  - `act_draw` pulses once; the break event has rel=1.
  - 6B gives an event with ext=0 and no action pulse.
- **Pause:** send E1 14 77 E1 F0 14 F0 77, then 3C.
  - No events for the first 8 bytes.
  - 3C gives an event and `act_uno`.
- **Timeout:** send E0, idle for `TIMEOUT_CYCLES` cycles, then send 5A.
  - `proto_err` pulses once.
  - 5A decodes with ext=0, and `act_select` pulses.
- **Illegal order:** send F0 E0 74.
  - `proto_err` pulses on E0.
  - Then an event (74, ext=1, rel=0) and `act_right`.
- **Reset:** assert `resetn` low after E0 with `key_strobe` held high, then release.
  - No spurious event at release.
  - The next byte 5A decodes as non-extended, and all outputs read their reset values before it.
